// File: rtl/assign_chain_checker.sv
// rtl/assign_chain_checker.sv - register chain with a built-in shadow model and sticky mismatch flag
module assign_chain_checker #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int MODE  = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             inject_err,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             ERROR,
  output logic [CNT_W-1:0] check_count
);

  logic [WIDTH-1:0] stage  [DEPTH];
  logic [WIDTH-1:0] shadow [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] word;
  logic             stages_eq;
  logic             compare;
  logic             mismatch;

  // The fault only corrupts the real chain; the shadow always sees clean data.
  assign word = in_data ^ WIDTH'(in_valid & inject_err);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i]  <= '0;
        shadow[i] <= '0;
      end
      vld <= '0;
    end else if (MODE == 0) begin
      stage[0]  <= word;
      shadow[0] <= in_data;
      vld[0]    <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i]  <= stage[i-1];
        shadow[i] <= shadow[i-1];
        vld[i]    <= vld[i-1];
      end
    end else begin
      // Cascade: every stage ends up holding the new word within one edge.
      vld <= {DEPTH{in_valid}};
      if (in_valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage[i]  <= word;
          shadow[i] <= in_data;
        end
      end
    end
  end

  always_comb begin
    stages_eq = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      if (stage[i] != stage[0]) stages_eq = 1'b0;
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = stage[DEPTH-1];
  assign compare   = out_valid;
  assign mismatch  = (out_data != shadow[DEPTH-1]) || ((MODE == 1) && !stages_eq);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ERROR       <= 1'b0;
      check_count <= '0;
    end else begin
      if (compare && mismatch) ERROR <= 1'b1;
      if (compare && (check_count != {CNT_W{1'b1}})) check_count <= check_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_assign_chain_checker.sv
// tb/tb_assign_chain_checker.sv - randomized self-checking bench against an input-history model
module tb_assign_chain_checker;

  localparam int NI = 5;
  localparam int HN = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       inject_err = 1'b0;

  logic        ov [NI];
  logic [7:0]  od [NI];
  logic        er [NI];
  logic [15:0] cc [NI];
  logic [15:0] cc0, cc1, cc3, cc4;
  logic [1:0]  cc2;

  int checks = 0;
  int errors = 0;

  // Per-instance configuration: mode, depth, saturation limit of check_count.
  int pm   [NI] = '{0, 1, 0, 0, 1};
  int pd   [NI] = '{4, 4, 4, 1, 1};
  int pmax [NI] = '{65535, 65535, 3, 65535, 65535};

  // Input history, one entry per clock edge.
  logic       hv [HN];
  logic [7:0] hd [HN];
  logic       hi [HN];
  logic       hr [HN];
  int         e = -1;
  int         mcnt [NI];
  logic       merr [NI];

  always #5 clk = ~clk;

  assign cc[0] = cc0;
  assign cc[1] = cc1;
  assign cc[2] = {14'b0, cc2};
  assign cc[3] = cc3;
  assign cc[4] = cc4;

  assign_chain_checker #(.WIDTH(8), .DEPTH(4), .MODE(0), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .inject_err(inject_err),
    .out_valid(ov[0]), .out_data(od[0]), .ERROR(er[0]), .check_count(cc0));
  assign_chain_checker #(.WIDTH(8), .DEPTH(4), .MODE(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .inject_err(inject_err),
    .out_valid(ov[1]), .out_data(od[1]), .ERROR(er[1]), .check_count(cc1));
  assign_chain_checker #(.WIDTH(8), .DEPTH(4), .MODE(0), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .inject_err(inject_err),
    .out_valid(ov[2]), .out_data(od[2]), .ERROR(er[2]), .check_count(cc2));
  assign_chain_checker #(.WIDTH(8), .DEPTH(1), .MODE(0), .CNT_W(16)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .inject_err(inject_err),
    .out_valid(ov[3]), .out_data(od[3]), .ERROR(er[3]), .check_count(cc3));
  assign_chain_checker #(.WIDTH(8), .DEPTH(1), .MODE(1), .CNT_W(16)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .inject_err(inject_err),
    .out_valid(ov[4]), .out_data(od[4]), .ERROR(er[4]), .check_count(cc4));

  task automatic check(input string nm, input int n, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h (edge %0d)", nm, n, act, exp, e);
    end
  endtask

  // Output after edge ee, derived from the input history: shift mode shows the
  // word taken dp-1 edges earlier unless a reset intervened; cascade mode shows
  // the most recent accepted word since the last reset.
  function automatic void model(input int m, input int dp, input int ee,
                                output logic v, output logic [7:0] d, output logic bad);
    int   j;
    logic ok;
    logic done;
    v = 1'b0; d = 8'h00; bad = 1'b0;
    if (m == 0) begin
      j = ee - dp + 1;
      if (j >= 0) begin
        ok = 1'b1;
        for (int k = j; k <= ee; k++) if (!hr[k]) ok = 1'b0;
        if (ok) begin
          v   = hv[j];
          bad = hv[j] & hi[j];
          d   = hd[j] ^ {7'b0, bad};
        end
      end
    end else begin
      v = hr[ee] & hv[ee];
      done = 1'b0;
      for (int k = ee; k >= 0; k--) begin
        if (!done) begin
          if (!hr[k]) done = 1'b1;
          else if (hv[k]) begin
            bad  = hi[k];
            d    = hd[k] ^ {7'b0, bad};
            done = 1'b1;
          end
        end
      end
    end
    bad = bad & v;
  endfunction

  always @(posedge clk) begin
    logic       v, b;
    logic [7:0] d;
    if (e >= 0) begin
      for (int n = 0; n < NI; n++) begin
        model(pm[n], pd[n], e, v, d, b);
        if (v && mcnt[n] < pmax[n]) mcnt[n] = mcnt[n] + 1;
        if (b) merr[n] = 1'b1;
      end
    end
    if (e < HN - 1) e = e + 1;
    hv[e] = in_valid;
    hd[e] = in_data;
    hi[e] = inject_err;
    hr[e] = rst_n;
    if (!rst_n) begin
      for (int n = 0; n < NI; n++) begin
        mcnt[n] = 0;
        merr[n] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic       v, b;
    logic [7:0] d;
    if (e >= 0) begin
      for (int n = 0; n < NI; n++) begin
        model(pm[n], pd[n], e, v, d, b);
        check("out_valid", n, longint'(ov[n]), longint'(v));
        check("out_data", n, longint'(od[n]), longint'(d));
        check("ERROR", n, longint'(er[n]), longint'(merr[n]));
        check("check_count", n, longint'(cc[n]), longint'(mcnt[n]));
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic ie, input logic r);
    in_valid   = v;
    in_data    = d;
    inject_err = ie;
    rst_n      = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("pin reset out_valid", 0, longint'(ov[0]), 0);
    check("pin reset out_data", 0, longint'(od[0]), 0);
    check("pin reset ERROR", 0, longint'(er[0]), 0);
    check("pin reset count", 0, longint'(cc[0]), 0);

    // Shift pipeline latency and ordering.
    drive(1'b1, 8'h01, 1'b0, 1'b1);
    drive(1'b1, 8'h02, 1'b0, 1'b1);
    drive(1'b1, 8'h03, 1'b0, 1'b1);
    check("pin t1 not yet valid", 0, longint'(ov[0]), 0);
    drive(1'b1, 8'h04, 1'b0, 1'b1);
    check("pin t1 first valid", 0, longint'(ov[0]), 1);
    check("pin t1 word0", 0, longint'(od[0]), 8'h01);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("pin t1 word1", 0, longint'(od[0]), 8'h02);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("pin t1 word2", 0, longint'(od[0]), 8'h03);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("pin t1 word3", 0, longint'(od[0]), 8'h04);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("pin t1 drained", 0, longint'(ov[0]), 0);
    check("pin t1 count", 0, longint'(cc[0]), 4);
    check("pin t1 ERROR", 0, longint'(er[0]), 0);

    // Cascade: one cycle latency, hold without in_valid.
    drive(1'b1, 8'h11, 1'b0, 1'b1);
    check("pin t2 first", 1, longint'(od[1]), 8'h11);
    check("pin t2 first valid", 1, longint'(ov[1]), 1);
    drive(1'b1, 8'h22, 1'b0, 1'b1);
    check("pin t2 second", 1, longint'(od[1]), 8'h22);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("pin t2 hold data", 1, longint'(od[1]), 8'h22);
    check("pin t2 hold valid", 1, longint'(ov[1]), 0);
    check("pin t2 ERROR", 1, longint'(er[1]), 0);

    // Bubble propagation.
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'hA0, 1'b0, 1'b1);
    drive(1'b0, 8'h55, 1'b0, 1'b1);
    drive(1'b1, 8'hA2, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("pin t3 v0", 0, longint'(ov[0]), 1);
    check("pin t3 d0", 0, longint'(od[0]), 8'hA0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("pin t3 bubble", 0, longint'(ov[0]), 0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("pin t3 d2", 0, longint'(od[0]), 8'hA2);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("pin t3 count", 0, longint'(cc[0]), 2);

    // Injected fault is flagged and stays flagged.
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h03, 1'b1, 1'b1);
    check("pin t4 cascade data", 1, longint'(od[1]), 8'h02);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("pin t4 cascade ERROR", 1, longint'(er[1]), 1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("pin t4 corrupted word", 0, longint'(od[0]), 8'h02);
    check("pin t4 ERROR not yet", 0, longint'(er[0]), 0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("pin t4 ERROR set", 0, longint'(er[0]), 1);
    for (int i = 0; i < 10; i++) drive(1'b1, 8'(i + 16), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("pin t4 ERROR sticky", 0, longint'(er[0]), 1);

    // Reset with words in flight.
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h31, 1'b0, 1'b1);
    drive(1'b1, 8'h32, 1'b0, 1'b1);
    drive(1'b1, 8'h33, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("pin t5 after reset", 0, longint'(ov[0]), 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      check("pin t5 flushed", 0, longint'(ov[0]), 0);
    end
    check("pin t5 ERROR", 0, longint'(er[0]), 0);
    check("pin t5 count", 0, longint'(cc[0]), 0);

    // Narrow counter saturates.
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(i + 64), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("pin t6 saturated", 2, longint'(cc[2]), 3);
    check("pin t6 ERROR", 2, longint'(er[2]), 0);

    // Random traffic with occasional faults and resets.
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0,
            $urandom_range(0, 99) != 0);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
